// File: rtl/ptp_reg_arbiter.sv
`timescale 1ns/1ps
// ptp_reg_arbiter
//
// Two-requester arbiter in front of the PTP core register bus. Requester 0 is
// the host software agent and requester 1 is the interrupt/timestamp service
// engine. Ties are broken round-robin, and each granted access is run to
// completion as a single bus transaction.
//
// Build option:
//   PTP_ARB_LOCK_EN - when defined, a grantee that holds its lock input high
//                     in the DONE cycle keeps the grant for its next request.
//                     This allows atomic multi-register sequences such as
//                     reading the RTC seconds and nanoseconds together. When
//                     the macro is undefined, lock0_i/lock1_i are ignored.
//
// Parameter:
//   RD_LAT          - cycles from the bus2ip_rd_ce_o pulse until the edge at
//                     which ip2bus_data_i is captured (1..3).
//
// Ports:
//   bus2ip_clk, bus2ip_rst_n     clock, async active-low reset
//   reqN_i, wrN_i, addrN_i,      per-requester access request; the fields
//   wdataN_i, lockN_i            must stay stable while reqN_i is high
//   ackN_o, rdataN_o             one-cycle completion pulse; read data is
//                                valid only in that cycle
//   bus2ip_addr_o/data_o/rd_ce_o/wr_ce_o   core register bus (one-cycle access)
//   ip2bus_data_i                core register read data
module ptp_reg_arbiter #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst_n,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        wr0_i,
    input  logic        wr1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    input  logic        lock0_i,
    input  logic        lock1_i,
    output logic        ack0_o,
    output logic        ack1_o,
    output logic [31:0] rdata0_o,
    output logic [31:0] rdata1_o,
    output logic [31:0] bus2ip_addr_o,
    output logic [31:0] bus2ip_data_o,
    output logic        bus2ip_rd_ce_o,
    output logic        bus2ip_wr_ce_o,
    input  logic [31:0] ip2bus_data_i
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StDone
    } state_t;

    // Value of the wait counter in the final WAIT cycle.
    localparam logic [1:0] LastWait = 2'(RD_LAT - 1);

    state_t      r_state;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_wr;
    logic [1:0]  r_wait_cnt;
    logic        r_ack0;
    logic        r_ack1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_data;
    logic        r_rd_ce;
    logic        r_wr_ce;

    logic [1:0]  w_req;
    logic [1:0]  w_elig;
    logic        w_pick;
    logic        w_sel_wr;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;

    assign w_req = {req1_i, req0_i};

`ifdef PTP_ARB_LOCK_EN
    logic       r_lock_hold;
    logic [1:0] w_lock;
    logic       w_hold_active;

    assign w_lock = {lock1_i, lock0_i};
    // The hold persists while the holder is either requesting or still has
    // lock asserted; during that time only the holder is eligible.
    assign w_hold_active = r_lock_hold & (w_req[r_grant] | w_lock[r_grant]);
    assign w_elig = w_hold_active ? (w_req & (r_grant ? 2'b10 : 2'b01)) : w_req;
`else
    logic w_unused_lock;

    assign w_unused_lock = lock0_i ^ lock1_i;
    assign w_elig        = w_req;
`endif

    // On a tie, the requester that was not granted last wins.
    assign w_pick      = (&w_elig) ? ~r_last_grant : w_elig[1];
    assign w_sel_wr    = w_pick ? wr1_i    : wr0_i;
    assign w_sel_addr  = w_pick ? addr1_i  : addr0_i;
    assign w_sel_wdata = w_pick ? wdata1_i : wdata0_i;

    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            r_state      <= StIdle;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_wr         <= 1'b0;
            r_wait_cnt   <= 2'd0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_rdata0     <= 32'd0;
            r_rdata1     <= 32'd0;
            r_bus_addr   <= 32'd0;
            r_bus_data   <= 32'd0;
            r_rd_ce      <= 1'b0;
            r_wr_ce      <= 1'b0;
`ifdef PTP_ARB_LOCK_EN
            r_lock_hold  <= 1'b0;
`endif
        end else begin
            // Outputs are one-cycle pulses; each state sets only what it needs.
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rdata0   <= 32'd0;
            r_rdata1   <= 32'd0;
            r_bus_addr <= 32'd0;
            r_bus_data <= 32'd0;
            r_rd_ce    <= 1'b0;
            r_wr_ce    <= 1'b0;

            case (r_state)
                StIdle: begin
`ifdef PTP_ARB_LOCK_EN
                    if (!w_hold_active) begin
                        r_lock_hold <= 1'b0;
                    end
`endif
                    if (|w_elig) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_wr         <= w_sel_wr;
                        r_bus_addr   <= w_sel_addr;
                        r_bus_data   <= w_sel_wdata;
                        r_wr_ce      <= w_sel_wr;
                        r_rd_ce      <= ~w_sel_wr;
                        r_state      <= StAccess;
                    end
                end

                StAccess: begin
                    if (r_wr) begin
                        r_ack0  <= ~r_grant;
                        r_ack1  <= r_grant;
                        r_state <= StDone;
                    end else begin
                        r_wait_cnt <= 2'd0;
                        r_state    <= StWait;
                    end
                end

                StWait: begin
                    if (r_wait_cnt == LastWait) begin
                        r_ack0   <= ~r_grant;
                        r_ack1   <= r_grant;
                        r_rdata0 <= r_grant ? 32'd0 : ip2bus_data_i;
                        r_rdata1 <= r_grant ? ip2bus_data_i : 32'd0;
                        r_state  <= StDone;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end

                StDone: begin
`ifdef PTP_ARB_LOCK_EN
                    r_lock_hold <= w_lock[r_grant];
`endif
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign ack0_o         = r_ack0;
    assign ack1_o         = r_ack1;
    assign rdata0_o       = r_rdata0;
    assign rdata1_o       = r_rdata1;
    assign bus2ip_addr_o  = r_bus_addr;
    assign bus2ip_data_o  = r_bus_data;
    assign bus2ip_rd_ce_o = r_rd_ce;
    assign bus2ip_wr_ce_o = r_wr_ce;

endmodule

// File: tb/tb_ptp_reg_arbiter.sv
`timescale 1ns/1ps
// Testbench for ptp_reg_arbiter (RD_LAT = 2). Expected acks are queued when
// requests are driven. They are popped and compared by the ack monitor.
module tb_ptp_reg_arbiter;

    localparam int unsigned RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
    logic        lock0 = 1'b0, lock1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, rd_ce, wr_ce;
    logic [31:0] rdata0, rdata1, bus_addr, bus_data, ip_data;

    ptp_reg_arbiter #(.RD_LAT(RD_LAT)) dut (
        .bus2ip_clk     (clk),
        .bus2ip_rst_n   (rst_n),
        .req0_i         (req0),
        .req1_i         (req1),
        .wr0_i          (wr0),
        .wr1_i          (wr1),
        .addr0_i        (addr0),
        .addr1_i        (addr1),
        .wdata0_i       (wdata0),
        .wdata1_i       (wdata1),
        .lock0_i        (lock0),
        .lock1_i        (lock1),
        .ack0_o         (ack0),
        .ack1_o         (ack1),
        .rdata0_o       (rdata0),
        .rdata1_o       (rdata1),
        .bus2ip_addr_o  (bus_addr),
        .bus2ip_data_o  (bus_data),
        .bus2ip_rd_ce_o (rd_ce),
        .bus2ip_wr_ce_o (wr_ce),
        .ip2bus_data_i  (ip_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          ack_cnt0 = 0;
    int          ack_cnt1 = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_addr = '0;
    bit          mon_en = 1'b0;

    function automatic logic [31:0] reg_val(input logic [31:0] a);
        return (a == 32'h0000_0024) ? 32'hCAFE_0001 : (a ^ 32'hA5A5_0000);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Register model: read data is valid only around the capture edge.
    always @(negedge clk) begin
        if (rd_ce) begin
            rd_cnt  = 1;
            rd_addr = bus_addr;
        end else if (rd_cnt != 0) begin
            rd_cnt = rd_cnt + 1;
        end
    end
    assign ip_data = (rd_cnt == RD_LAT + 1) ? reg_val(rd_addr) : 32'hDEAD_BEEF;

    // Ack monitor / scoreboard plus bus invariants.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (ack0 && ack1) begin
                failures++;
                $display("FAIL dual_ack cyc=%0d ack0=%b ack1=%b required one-hot", cyc, ack0, ack1);
            end
            checks++;
            if (rd_ce && wr_ce) begin
                failures++;
                $display("FAIL dual_ce cyc=%0d rd_ce=%b wr_ce=%b", cyc, rd_ce, wr_ce);
            end
            checks++;
            if (!rd_ce && !wr_ce && (bus_addr !== 32'd0 || bus_data !== 32'd0)) begin
                failures++;
                $display("FAIL bus_idle_zero cyc=%0d addr=%h data=%h required 0", cyc, bus_addr,
                         bus_data);
            end
            checks++;
            if ((!ack0 && rdata0 !== 32'd0) || (!ack1 && rdata1 !== 32'd0)) begin
                failures++;
                $display("FAIL rdata_idle_zero cyc=%0d rdata0=%h rdata1=%h required 0", cyc,
                         rdata0, rdata1);
            end
            if (ack0 || ack1) begin
                int          idx;
                logic [31:0] rd;
                exp_t        e;
                idx = ack1 ? 1 : 0;
                rd  = ack1 ? rdata1 : rdata0;
                if (ack0) ack_cnt0++;
                if (ack1) ack_cnt1++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ack cyc=%0d got ack%0d required none", cyc, idx);
                end else begin
                    e = sb_q.pop_front();
                    if (idx !== e.idx || rd !== e.rdata || (e.cyc >= 0 && cyc != e.cyc)) begin
                        failures++;
                        $display("FAIL ack_match got ack%0d rdata=%h cyc=%0d required ack%0d rdata=%h cyc=%0d",
                                 idx, rd, cyc, e.idx, e.rdata, e.cyc);
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drop_all();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [135:0] obs;
        #2;
        rst_n = 1'b0;
        #1;
        obs = {ack0, ack1, rd_ce, wr_ce, bus_addr, bus_data, rdata0, rdata1};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %h required 0", obs);
        end
        mon_en = 1'b1;
        // Requests during reset must not start anything.
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h8;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack0, wr_ce, rd_ce} !== 3'b000) begin
            failures++;
            $display("FAIL reset_hold got ack0/wr_ce/rd_ce=%b required 000", {ack0, wr_ce, rd_ce});
        end
        drop_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        int c0;
        bit ok;
        c0 = cyc;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h0000_0010; wdata0 = 32'h1234_5678;
        sb_q.push_back('{0, 32'd0, c0 + 2});
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rd_ce, wr_ce, bus_addr, bus_data} !== {1'b0, 1'b1, 32'h10, 32'h1234_5678}) begin
            failures++;
            $display("FAIL write_access got rd=%b wr=%b addr=%h data=%h required 0 1 10 12345678",
                     rd_ce, wr_ce, bus_addr, bus_data);
        end
        @(negedge clk);
        checks++;
        if (wr_ce !== 1'b0) begin
            failures++;
            $display("FAIL write_ce_pulse got wr_ce=%b required 0", wr_ce);
        end
        wait_drain(10, ok);
        drop_all();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL write_ack_timeout got pending=%0d required 0", sb_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_read();
        int c0;
        bit ok;
        c0 = cyc;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_0024; wdata1 = 32'd0;
        sb_q.push_back('{1, 32'hCAFE_0001, c0 + 4});
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({rd_ce, wr_ce, bus_addr} !== {1'b1, 1'b0, 32'h24}) begin
            failures++;
            $display("FAIL read_access got rd=%b wr=%b addr=%h required 1 0 24", rd_ce, wr_ce,
                     bus_addr);
        end
        @(negedge clk);
        checks++;
        if ({rd_ce, ack1} !== 2'b00) begin
            failures++;
            $display("FAIL read_wait got rd_ce/ack1=%b required 00", {rd_ce, ack1});
        end
        wait_drain(12, ok);
        drop_all();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL read_ack_timeout got pending=%0d required 0", sb_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        int c0;
        bit ok;
        apply_reset(2);
        // apply_reset released reset just now; set requests before the next edge.
        c0 = cyc;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h100; wdata0 = 32'h1;
        req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h200; wdata1 = 32'h2;
        sb_q.push_back('{0, 32'd0, c0 + 2});
        sb_q.push_back('{1, 32'd0, c0 + 5});
        sb_q.push_back('{0, 32'd0, c0 + 8});
        sb_q.push_back('{1, 32'd0, c0 + 11});
        wait_drain(30, ok);
        drop_all();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rr_timeout got pending=%0d required 0", sb_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_lock();
        int  c0, b0, b1;
        bit  ok;
        apply_reset(2);
        c0 = cyc;
        b0 = ack_cnt0;
        b1 = ack_cnt1;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h30; wdata0 = 32'h3;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h40; wdata1 = 32'd0; lock1 = 1'b1;
        sb_q.push_back('{0, 32'd0, c0 + 2});
        sb_q.push_back('{1, reg_val(32'h40), c0 + 7});
`ifdef PTP_ARB_LOCK_EN
        sb_q.push_back('{1, reg_val(32'h40), c0 + 12});
        sb_q.push_back('{0, 32'd0, c0 + 15});
`else
        sb_q.push_back('{0, 32'd0, c0 + 10});
        sb_q.push_back('{1, reg_val(32'h40), c0 + 15});
`endif
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ack_cnt1 - b1 >= 1) lock1 = 1'b0;
            if (ack_cnt1 - b1 >= 2) req1 = 1'b0;
            if ((ack_cnt0 - b0) + (ack_cnt1 - b1) >= 4) begin
                req0 = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        drop_all();
        checks++;
        if (!ok || sb_q.size() != 0) begin
            failures++;
            $display("FAIL lock_timeout got pending=%0d required 0", sb_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_wait();
        int c1;
        bit ok;
        logic [135:0] obs;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_0024; wdata1 = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        // Now in the first WAIT cycle of the read.
        rst_n = 1'b0;
        #1;
        obs = {ack0, ack1, rd_ce, wr_ce, bus_addr, bus_data, rdata0, rdata1};
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_wait_outputs got %h required 0", obs);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        c1 = cyc;
        sb_q.push_back('{1, 32'hCAFE_0001, c1 + 4});
        wait_drain(12, ok);
        drop_all();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_wait_regrant got pending=%0d required 0", sb_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_drop_req();
        int c0;
        int n_ce;
        c0 = cyc;
        n_ce = 0;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h50; wdata0 = 32'h5555_AAAA;
        sb_q.push_back('{0, 32'd0, c0 + 2});
        @(posedge clk);
        #1;
        req0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wr_ce || rd_ce) n_ce++;
            if (i != 7) @(posedge clk);
        end
        checks++;
        if (n_ce != 1 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL drop_req got ce_count=%0d pending=%0d required 1 0", n_ce, sb_q.size());
        end
        #1;
    endtask

    task automatic test_back_to_back();
        int c0;
        bit ok;
        c0 = cyc;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h60; wdata0 = 32'h6;
        sb_q.push_back('{0, 32'd0, c0 + 2});
        sb_q.push_back('{0, 32'd0, c0 + 5});
        wait_drain(15, ok);
        drop_all();
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL back_to_back got pending=%0d required 0", sb_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0 || wr_ce !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_idle got pending=%0d wr_ce=%b required 0 0", sb_q.size(),
                     wr_ce);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_lock();
        test_reset_in_wait();
        test_drop_req();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
